// File: rtl/chip8_pkg.sv
// Shared types and constants for the Chip-8 program-memory loader.
package chip8_pkg;

   localparam int unsigned ADDR_W = 12;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned SUM_W  = 16;

   // Program space starts above the font/interpreter area; top of 4 KiB map.
   localparam logic [ADDR_W-1:0] LOAD_BASE_DEF = 12'h200;
   localparam logic [ADDR_W-1:0] MEM_TOP_DEF   = 12'hFFF;

   typedef enum logic [1:0] {
      LDR_IDLE   = 2'd0,
      LDR_CLEAR  = 2'd1,
      LDR_LOAD   = 2'd2,
      LDR_VERIFY = 2'd3
   } ldr_state_e;

   // One port-A access as issued by the loader.
   typedef struct packed {
      logic              en;
      logic              write;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } mem_req_t;

endpackage

// File: rtl/rom_loader_if.sv
// Download stream plus port-A memory bus seen by the ROM loader.
interface rom_loader_if;
   import chip8_pkg::*;

   logic              dl_start;
   logic              dl_valid;
   logic [DATA_W-1:0] dl_data;
   logic              dl_last;
   logic              dl_ready;

   logic              mem_en;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   // Loader side: consumes the download, drives port A.
   modport master (
      input  dl_start, dl_valid, dl_data, dl_last, mem_rdata,
      output dl_ready, mem_en, mem_write, mem_addr, mem_wdata
   );

   // Host/memory side.
   modport slave (
      output dl_start, dl_valid, dl_data, dl_last, mem_rdata,
      input  dl_ready, mem_en, mem_write, mem_addr, mem_wdata
   );

endinterface

// File: rtl/ldr_sum.sv
// 16-bit wrapping byte accumulator with synchronous clear and enable.
module ldr_sum
   import chip8_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clr_i,
   input  logic              en_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [SUM_W-1:0]  sum_o
);

   logic [SUM_W-1:0] sum_q;
   logic [SUM_W-1:0] sum_d;

   // Clear has priority over accumulation.
   always_comb begin
      sum_d = sum_q;
      if (clr_i) begin
         sum_d = '0;
      end else if (en_i) begin
         sum_d = sum_q + SUM_W'(data_i);
      end
   end

   // Accumulator register.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end

   assign sum_o = sum_q;

endmodule

// File: rtl/rom_loader.sv
// Port-A writer for Chip-8 program memory: clear, load, read-back verify.
module rom_loader
   import chip8_pkg::*;
#(
   parameter logic [ADDR_W-1:0] LOAD_BASE = LOAD_BASE_DEF,
   parameter logic [ADDR_W-1:0] MEM_TOP   = MEM_TOP_DEF,
   parameter bit                CLEAR_EN  = 1'b1
) (
   input  logic              a_clk,
   input  logic              reset_n,
   rom_loader_if.master      ldr_bus,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic              verify_err,
   output logic [ADDR_W-1:0] byte_count
);

   localparam logic [1:0] S_IDLE   = LDR_IDLE;
   localparam logic [1:0] S_CLEAR  = LDR_CLEAR;
   localparam logic [1:0] S_LOAD   = LDR_LOAD;
   localparam logic [1:0] S_VERIFY = LDR_VERIFY;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              full_q, full_d;
   logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
   logic              cap_q, cap_d;
   logic              done_q, done_d;
   logic              overflow_q, overflow_d;
   logic              verify_err_q, verify_err_d;
   logic [ADDR_W-1:0] byte_count_q, byte_count_d;
   logic              cpu_hold_q;
   logic              busy_q;
   logic              dl_ready_q;

   mem_req_t          req_c;
   logic              sum_clr_c;
   logic              load_en_c;
   logic              rd_en_c;
   logic [SUM_W-1:0]  load_sum_c;
   logic [SUM_W-1:0]  rd_sum_c;
   logic [SUM_W-1:0]  rd_total_c;

   // Running sum of bytes actually written during LOAD.
   ldr_sum u_load_sum (
      .clk     (a_clk),
      .reset_n (reset_n),
      .clr_i   (sum_clr_c),
      .en_i    (load_en_c),
      .data_i  (ldr_bus.dl_data),
      .sum_o   (load_sum_c)
   );

   // Running sum of bytes read back during VERIFY.
   ldr_sum u_rd_sum (
      .clk     (a_clk),
      .reset_n (reset_n),
      .clr_i   (sum_clr_c),
      .en_i    (rd_en_c),
      .data_i  (ldr_bus.mem_rdata),
      .sum_o   (rd_sum_c)
   );

   // Read-back total including the byte arriving this cycle.
   assign rd_total_c = rd_sum_c + (cap_q ? SUM_W'(ldr_bus.mem_rdata) : SUM_W'(0));

   // Next-state, port-A request and bookkeeping.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      full_d       = full_q;
      rd_cnt_d     = rd_cnt_q;
      cap_d        = 1'b0;
      done_d       = 1'b0;
      overflow_d   = overflow_q;
      verify_err_d = verify_err_q;
      byte_count_d = byte_count_q;
      sum_clr_c    = 1'b0;
      load_en_c    = 1'b0;
      rd_en_c      = 1'b0;
      req_c        = '0;

      case (state_q)
         S_IDLE: begin
            if (ldr_bus.dl_start) begin
               state_d      = CLEAR_EN ? S_CLEAR : S_LOAD;
               addr_d       = LOAD_BASE;
               full_d       = 1'b0;
               rd_cnt_d     = '0;
               overflow_d   = 1'b0;
               verify_err_d = 1'b0;
               byte_count_d = '0;
               sum_clr_c    = 1'b1;
            end
         end

         S_CLEAR: begin
            req_c.en    = 1'b1;
            req_c.write = 1'b1;
            req_c.addr  = addr_q;
            req_c.data  = '0;
            if (addr_q == MEM_TOP) begin
               addr_d  = LOAD_BASE;
               state_d = S_LOAD;
            end else begin
               addr_d = addr_q + ADDR_W'(1);
            end
         end

         S_LOAD: begin
            if (ldr_bus.dl_valid) begin
               if (!full_q) begin
                  req_c.en     = 1'b1;
                  req_c.write  = 1'b1;
                  req_c.addr   = addr_q;
                  req_c.data   = ldr_bus.dl_data;
                  load_en_c    = 1'b1;
                  byte_count_d = byte_count_q + ADDR_W'(1);
                  // Saturate at the top so font space is never targeted.
                  if (addr_q == MEM_TOP) begin
                     full_d = 1'b1;
                  end else begin
                     addr_d = addr_q + ADDR_W'(1);
                  end
               end else begin
                  overflow_d = 1'b1;
               end
               if (ldr_bus.dl_last) begin
                  state_d  = S_VERIFY;
                  addr_d   = LOAD_BASE;
                  rd_cnt_d = '0;
               end
            end
         end

         S_VERIFY: begin
            // Issue one read per cycle until byte_count reads are out.
            if (rd_cnt_q != byte_count_q) begin
               req_c.en    = 1'b1;
               req_c.write = 1'b0;
               req_c.addr  = addr_q;
               rd_cnt_d    = rd_cnt_q + ADDR_W'(1);
               cap_d       = 1'b1;
               if (addr_q != MEM_TOP) begin
                  addr_d = addr_q + ADDR_W'(1);
               end
            end
            rd_en_c = cap_q;
            // All reads issued and the last datum is arriving (or none were needed).
            if (rd_cnt_q == byte_count_q) begin
               verify_err_d = (rd_total_c != load_sum_c);
               done_d       = 1'b1;
               state_d      = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge a_clk) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         full_q       <= 1'b0;
         rd_cnt_q     <= '0;
         cap_q        <= 1'b0;
         done_q       <= 1'b0;
         overflow_q   <= 1'b0;
         verify_err_q <= 1'b0;
         byte_count_q <= '0;
         cpu_hold_q   <= 1'b0;
         busy_q       <= 1'b0;
         dl_ready_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         full_q       <= full_d;
         rd_cnt_q     <= rd_cnt_d;
         cap_q        <= cap_d;
         done_q       <= done_d;
         overflow_q   <= overflow_d;
         verify_err_q <= verify_err_d;
         byte_count_q <= byte_count_d;
         // Hold follows the registered state, so it trails busy by one cycle.
         cpu_hold_q   <= (state_q != S_IDLE);
         busy_q       <= (state_d != S_IDLE);
         dl_ready_q   <= (state_d == S_LOAD);
      end
   end

   // Port A must see a LOAD write in the same cycle as the transfer.
   assign ldr_bus.mem_en    = req_c.en;
   assign ldr_bus.mem_write = req_c.write;
   assign ldr_bus.mem_addr  = req_c.addr;
   assign ldr_bus.mem_wdata = req_c.data;
   assign ldr_bus.dl_ready  = dl_ready_q;

   assign cpu_hold   = cpu_hold_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign overflow   = overflow_q;
   assign verify_err = verify_err_q;
   assign byte_count = byte_count_q;

endmodule
